// File: rtl/sm_hex_scanner_if.sv
// Display bus for sm_hex_scanner: the word to show plus its display controls,
// and the multiplexed 7-segment drive coming back from the scanner.
interface sm_hex_scanner_if #(
  parameter int DIGITS = 8
);
  logic [31:0]       data;
  logic              hold;
  logic              blank_lz;
  logic [DIGITS-1:0] dp;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic              frame_done;

  // Source of the debug word and display controls.
  modport master (
    output data, hold, blank_lz, dp,
    input  an_n, seg_n, dp_n, frame_done
  );

  // The scanner itself.
  modport slave (
    input  data, hold, blank_lz, dp,
    output an_n, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/sm_hex_scanner.sv
// Time-multiplexed hex display driver for a common-anode 7-segment array.
// The input word is snapshotted once per frame, optional leading-zero
// blanking is applied, and every slot begins with a few dark cycles so the
// previous digit's pattern cannot ghost onto the next anode. All outputs
// are registered (one cycle latency).
module sm_hex_scanner #(
  parameter int DIGITS      = 8,
  parameter int SCAN_CYCLES = 50000,
  parameter int DEAD        = 2
) (
  input logic              clk,
  input logic              rst,
  sm_hex_scanner_if.slave  bus
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_C    = CW'(DEAD);
  localparam logic [2:0]    DIGIT_MAX = 3'(DIGITS - 1);

  logic [CW-1:0]     cnt;
  logic [2:0]        digit;
  logic [31:0]       shadow;
  logic              frame_end;

  logic [DIGITS-1:0] blanked;
  logic [3:0]        nibble;
  logic              lit;
  logic [DIGITS-1:0] an_next;
  logic [6:0]        seg_next;
  logic              dp_next;

  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              frame_done_q;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign frame_end = (cnt == CNT_MAX) && (digit == DIGIT_MAX);
  assign nibble    = shadow[{digit, 2'b00} +: 4];

  // Leading-zero mask: walk down from the top nibble while everything seen is zero.
  always_comb begin
    logic run;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    blanked = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run        = run & (shadow[4*i +: 4] == 4'h0);
      blanked[i] = bus.blank_lz & run & (i != 0);
    end
  end

  // Next display drive for the current slot; dark unless this digit is lit.
  always_comb begin
    lit      = (cnt >= DEAD_C) && !blanked[digit];
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (lit) begin
      an_next[digit] = 1'b0;
      seg_next       = hex7(nibble);
      dp_next        = ~bus.dp[digit];
    end
  end

  // Slot/digit counters, per-frame snapshot and the registered output stage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cnt          <= '0;
      digit        <= '0;
      shadow       <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt   <= '0;
        digit <= (digit == DIGIT_MAX) ? 3'd0 : digit + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (frame_end && !bus.hold) shadow <= bus.data;
      frame_done_q <= frame_end;
      an_q         <= an_next;
      seg_q        <= seg_next;
      dp_q         <= dp_next;
    end
  end

  assign bus.an_n       = an_q;
  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sm_hex_scanner.sv
// Scoreboard bench for sm_hex_scanner. A reference model derives the expected
// display from elapsed cycles since reset and the snapshotted word, pushing one
// expectation per clock; a monitor pops and compares on the falling edge.
module tb_sm_hex_scanner;

  localparam int D  = 8;
  localparam int SC = 4;
  localparam int DD = 1;
  localparam int FRAME = D * SC;

  typedef struct packed {
    logic [D-1:0] an_n;
    logic [6:0]   seg_n;
    logic         dp_n;
    logic         frame_done;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sm_hex_scanner_if #(.DIGITS(D)) bus ();

  sm_hex_scanner #(
    .DIGITS(D),
    .SCAN_CYCLES(SC),
    .DEAD(DD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  out_t        exp_q [$];
  int          total = 0;
  int          bad   = 0;
  int unsigned t_m   = 0;  // cycles since the scan (re)started
  logic [31:0] sh_m  = '0; // model snapshot

  // Free-running board clock.
  always #5 clk = ~clk;

  // Reference model: expected outputs after each rising edge.
  initial begin
    out_t        e;
    int          c, k;
    logic [31:0] upper;
    forever begin
      @(posedge clk);
      e.an_n       = '1;
      e.seg_n      = 7'h7F;
      e.dp_n       = 1'b1;
      e.frame_done = 1'b0;
      if (rst) begin
        t_m  = 0;
        sh_m = '0;
      end else begin
        c     = int'(t_m % SC);
        k     = int'((t_m / SC) % D);
        upper = sh_m >> (4 * k);
        e.frame_done = ((t_m % FRAME) == FRAME - 1);
        if (c >= DD && !(bus.blank_lz && k > 0 && upper == 0)) begin
          e.an_n  = ~(8'b1 << k);
          e.seg_n = hex_tab[upper[3:0]];
          e.dp_n  = ~bus.dp[k];
        end
        if (e.frame_done && !bus.hold) sh_m = bus.data;
        t_m++;
      end
      exp_q.push_back(e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expectation, away from the active edge.
  initial begin
    out_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{an_n: bus.an_n, seg_n: bus.seg_n, dp_n: bus.dp_n, frame_done: bus.frame_done};
        check("outputs", 32'(a), 32'(e));
        check("anode_exclusive", 32'($countones(~bus.an_n) <= 1), 32'd1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] d, input logic h, input logic b, input logic [D-1:0] p);
    bus.data     = d;
    bus.hold     = h;
    bus.blank_lz = b;
    bus.dp       = p;
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int budget;
    set_in(32'h0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(13);
    // reset mid-scan
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(5);

    // leading-zero blanking
    set_in(32'h000000A5, 1'b0, 1'b1, '0);
    cyc(3 * FRAME);

    // hold across frames, then release
    bus.hold = 1'b1;
    cyc(10);
    bus.data = 32'h12345678;
    cyc(3 * FRAME);
    bus.hold = 1'b0;
    cyc(2 * FRAME);

    // slot timing with all F
    set_in(32'hFFFFFFFF, 1'b0, 1'b0, '0);
    cyc(3 * FRAME);

    // no blanking, decimal points on outer digits
    set_in(32'h0, 1'b0, 1'b0, 8'b10000001);
    cyc(3 * FRAME);

    // reset coinciding with a frame end
    set_in(32'h1, 1'b0, 1'b1, '0);
    budget = 0;
    while ((t_m % FRAME) != FRAME - 1 && budget < 2 * FRAME) begin
      cyc(1);
      budget++;
    end
    check("frame_end_reached", 32'(budget < 2 * FRAME), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2 * FRAME);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      set_in($urandom >> $urandom_range(0, 31), ($urandom_range(0, 9) < 3),
             1'($urandom), D'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      cyc($urandom_range(5, 40));
    end

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
